// File: rtl/bus_fifo_endpoint.sv
// rtl/bus_fifo_endpoint.sv - bus endpoint with FWFT TX/RX FIFOs, ID filtering, sticky error flags (optional BUS_EP_DROP_CNT_EN)
module bus_fifo_endpoint #(
    parameter int          pckg_sz = 16,
    parameter int          depth   = 8,
    parameter logic [7:0]  id      = 8'd0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               tx_full,
    input  logic               rd_en,
    output logic [pckg_sz-1:0] rd_data,
    output logic               rx_valid,
    output logic               rx_ovf,
`ifdef BUS_EP_DROP_CNT_EN
    output logic [7:0]         drop_cnt,
`endif
    output logic               tx_err
);

    localparam int aw = $clog2(depth);

    typedef logic [aw:0] ptr_t;

    // Storage is never reset; only the pointers define what is valid.
    logic [pckg_sz-1:0] tx_mem [depth];
    logic [pckg_sz-1:0] rx_mem [depth];

    ptr_t tx_wp, tx_rp, rx_wp, rx_rp;

    logic tx_empty, rx_empty, rx_full;
    logic tx_rd, tx_wr, tx_rej, tx_self;
    logic rx_rd, rx_wr, rx_drop, rx_match;

    // Pointer-derived status: the extra MSB distinguishes full from empty.
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[aw] != tx_rp[aw]) && (tx_wp[aw-1:0] == tx_rp[aw-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[aw] != rx_rp[aw]) && (rx_wp[aw-1:0] == rx_rp[aw-1:0]);

    assign pndng    = !tx_empty;
    assign rx_valid = !rx_empty;

    // First-word-fall-through heads read straight from storage.
    assign D_pop   = tx_mem[tx_rp[aw-1:0]];
    assign rd_data = rx_mem[rx_rp[aw-1:0]];

    // TX side: a pop in the same cycle frees the slot a full-FIFO write needs.
    assign tx_self = (wr_data[pckg_sz-1 -: 8] == id);
    assign tx_rd   = pop && !tx_empty;
    assign tx_wr   = wr_en && !tx_self && (!tx_full || tx_rd);
    assign tx_rej  = wr_en && !tx_wr;

    // RX side: only our ID or broadcast is kept; the bus cannot be stalled.
    assign rx_match = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == 8'hFF);
    assign rx_rd    = rd_en && !rx_empty;
    assign rx_wr    = push && rx_match && (!rx_full || rx_rd);
    assign rx_drop  = push && rx_match && rx_full && !rx_rd;

    // Write accepted packets into storage.
    always_ff @(posedge clk) begin
        if (tx_wr) tx_mem[tx_wp[aw-1:0]] <= wr_data;
        if (rx_wr) rx_mem[rx_wp[aw-1:0]] <= D_push;
    end

    // Advance pointers and accumulate the sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            tx_err <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (tx_wr)   tx_wp  <= tx_wp + 1'b1;
            if (tx_rd)   tx_rp  <= tx_rp + 1'b1;
            if (rx_wr)   rx_wp  <= rx_wp + 1'b1;
            if (rx_rd)   rx_rp  <= rx_rp + 1'b1;
            if (tx_rej)  tx_err <= 1'b1;
            if (rx_drop) rx_ovf <= 1'b1;
        end
    end

`ifdef BUS_EP_DROP_CNT_EN
    // Count RX overflow drops, holding at the top value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            drop_cnt <= 8'd0;
        else if (rx_drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_bus_fifo_endpoint.sv
// tb/tb_bus_fifo_endpoint.sv - self-checking bench for bus_fifo_endpoint against a queue-based model
module tb_bus_fifo_endpoint;

    localparam int         PW    = 16;
    localparam int         DEPTH = 8;
    localparam logic [7:0] ID    = 8'h02;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pndng, pop = 1'b0, push = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [PW-1:0] D_pop, D_push = '0, wr_data = '0, rd_data;
    logic          tx_full, rx_valid, rx_ovf, tx_err;
`ifdef BUS_EP_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    bus_fifo_endpoint #(.pckg_sz(PW), .depth(DEPTH), .id(ID)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push), .wr_en(wr_en), .wr_data(wr_data),
        .tx_full(tx_full), .rd_en(rd_en), .rd_data(rd_data), .rx_valid(rx_valid),
        .rx_ovf(rx_ovf),
`ifdef BUS_EP_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [PW-1:0] txq[$];
    logic [PW-1:0] rxq[$];
    logic          tx_err_m, rx_ovf_m;
    int            drop_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        txq.delete();
        rxq.delete();
        tx_err_m = 1'b0;
        rx_ovf_m = 1'b0;
        drop_m   = 0;
    endfunction

    function automatic void model_update();
        bit tx_take, wr_ok, rx_take, match, rx_ok;
        tx_take = pop && (txq.size() > 0);
        wr_ok   = wr_en && (wr_data[15:8] != ID) && ((txq.size() < DEPTH) || tx_take);
        if (wr_en && !wr_ok) tx_err_m = 1'b1;
        rx_take = rd_en && (rxq.size() > 0);
        match   = (D_push[15:8] == ID) || (D_push[15:8] == 8'hFF);
        rx_ok   = push && match && ((rxq.size() < DEPTH) || rx_take);
        if (push && match && !rx_ok) begin
            rx_ovf_m = 1'b1;
            if (drop_m < 255) drop_m++;
        end
        if (tx_take) void'(txq.pop_front());
        if (wr_ok)   txq.push_back(wr_data);
        if (rx_take) void'(rxq.pop_front());
        if (rx_ok)   rxq.push_back(D_push);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".pndng"},    pndng,    txq.size() != 0);
        chk({tag, ".tx_full"},  tx_full,  txq.size() == DEPTH);
        chk({tag, ".rx_valid"}, rx_valid, rxq.size() != 0);
        chk({tag, ".tx_err"},   tx_err,   tx_err_m);
        chk({tag, ".rx_ovf"},   rx_ovf,   rx_ovf_m);
        if (txq.size() != 0) chk({tag, ".D_pop"},   D_pop,   txq[0]);
        if (rxq.size() != 0) chk({tag, ".rd_data"}, rd_data, rxq[0]);
`ifdef BUS_EP_DROP_CNT_EN
        chk({tag, ".drop_cnt"}, drop_cnt, drop_m);
`endif
    endtask

    task automatic idle_inputs();
        pop = 1'b0; push = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
        idle_inputs();
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        reset = 1'b0;
        model_clear();
        #1;
        check_all(tag);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic tx_write(input logic [PW-1:0] d, input string tag);
        wr_en = 1'b1; wr_data = d;
        cycle(tag);
    endtask

    task automatic rx_push(input logic [PW-1:0] d, input string tag);
        push = 1'b1; D_push = d;
        cycle(tag);
    endtask

    logic [7:0] dest;

    initial begin
        model_clear();
        #12;
        check_all("reset");
        chk("reset.pndng_const", pndng, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // three packets in, three out in order
        for (int i = 0; i < 3; i++) tx_write(16'h0300 + 16'(i), "r035_wr");
        chk("r035.pndng", pndng, 1);
        chk("r035.D_pop", D_pop, 16'h0300);
        for (int i = 0; i < 3; i++) begin
            chk("r035.order", D_pop, 16'h0300 + 16'(i));
            pop = 1'b1;
            cycle("r035_pop");
        end
        chk("r035.empty", pndng, 0);
        pop = 1'b1;
        cycle("r035_pop_empty");

        // full TX: simultaneous pop+write keeps 8 entries, then overfill
        do_reset("rst_a");
        for (int i = 0; i < DEPTH; i++) tx_write(16'h0100 + 16'(i), "r036_fill");
        chk("r036.tx_full", tx_full, 1);
        pop = 1'b1; wr_en = 1'b1; wr_data = 16'h01AA;
        cycle("r039_popwr");
        chk("r039.tx_full", tx_full, 1);
        chk("r039.tx_err", tx_err, 0);
        tx_write(16'h01BB, "r036_ninth");
        chk("r036.tx_err", tx_err, 1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("r039.last", D_pop, 16'h01AA);
            pop = 1'b1;
            cycle("r039_drain");
        end
        chk("r039.empty", pndng, 0);

        // self-send is rejected
        do_reset("rst_b");
        tx_write(16'h0277, "self_send");
        chk("self.tx_err", tx_err, 1);
        chk("self.pndng", pndng, 0);

        // ID filtering
        do_reset("rst_c");
        rx_push(16'h02AB, "r037_a");
        rx_push(16'hFF11, "r037_b");
        rx_push(16'h0533, "r037_c");
        chk("r037.rx_valid", rx_valid, 1);
        chk("r037.head", rd_data, 16'h02AB);
        rd_en = 1'b1;
        cycle("r037_rd");
        chk("r037.second", rd_data, 16'hFF11);
        rd_en = 1'b1;
        cycle("r037_rd");
        chk("r037.empty", rx_valid, 0);
        chk("r037.no_ovf", rx_ovf, 0);

        // RX overflow, then push+read on full
        do_reset("rst_d");
        for (int i = 0; i < DEPTH; i++) rx_push(16'h0200 + 16'(i), "r038_fill");
        rx_push(16'h02EE, "r038_drop");
        chk("r038.rx_ovf", rx_ovf, 1);
`ifdef BUS_EP_DROP_CNT_EN
        chk("r038.drop_cnt", drop_cnt, 1);
`endif
        push = 1'b1; D_push = 16'hFF99; rd_en = 1'b1;
        cycle("r038_pushrd");
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("r038.accepted", rd_data, 16'hFF99);
            rd_en = 1'b1;
            cycle("r038_drain");
        end
        rd_en = 1'b1;
        cycle("r038_rd_empty");

        // asynchronous reset with entries queued
        do_reset("rst_e");
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 16'h0400 + 16'(i);
            push = 1'b1; D_push = 16'h0210 + 16'(i);
            cycle("r040_load");
        end
        #3;
        reset = 1'b0;
        model_clear();
        #1;
        chk("r040.pndng", pndng, 0);
        chk("r040.rx_valid", rx_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tx_write(16'h0377, "r040_wr");
        chk("r040.readback", D_pop, 16'h0377);
        rx_push(16'h0288, "r040_push");
        chk("r040.rx_readback", rd_data, 16'h0288);

        // randomized traffic against the model
        do_reset("rst_f");
        for (int i = 0; i < 600; i++) begin
            int r;
            bit heavy_in;
            heavy_in = ((i / 100) % 2) == 0;
            r = $urandom_range(0, 3);
            dest = (r == 0) ? ID : (r == 1) ? 8'hFF : (r == 2) ? 8'h03 : 8'($urandom_range(0, 255));
            D_push  = {dest, 8'($urandom_range(0, 255))};
            r = $urandom_range(0, 7);
            dest = (r == 0) ? ID : 8'($urandom_range(0, 255));
            wr_data = {dest, 8'($urandom_range(0, 255))};
            wr_en = ($urandom_range(0, 9) < (heavy_in ? 8 : 3));
            push  = ($urandom_range(0, 9) < (heavy_in ? 8 : 3));
            pop   = ($urandom_range(0, 9) < (heavy_in ? 3 : 8));
            rd_en = ($urandom_range(0, 9) < (heavy_in ? 3 : 8));
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_fifo_endpoint.md
BUS_FIFO_ENDPOINT -- requirements
Module: bus_fifo_endpoint

Interface
REQ-001 Parameter pckg_sz, default 16, packet width in bits.
REQ-002 Parameter depth, default 8, entries per FIFO; power of two, at least 2.
REQ-003 Parameter id, default 0, this endpoint's bus ID, 8 bits.
REQ-004 Port clk input 1: single clock; all state on rising edge.
REQ-005 Port reset input 1: asynchronous, active-low reset.
REQ-006 Port pndng output 1: TX FIFO non-empty; bus may pop.
REQ-007 Port D_pop output pckg_sz: TX FIFO head, valid while pndng=1.
REQ-008 Port pop input 1: bus consumes TX head this cycle.
REQ-009 Port push input 1: bus delivers a packet this cycle.
REQ-010 Port D_push input pckg_sz: packet delivered with push.
REQ-011 Port wr_en input 1: local side writes a TX packet.
REQ-012 Port wr_data input pckg_sz: TX packet; bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
REQ-013 Port tx_full output 1: TX FIFO holds depth entries.
REQ-014 Port rd_en input 1: local side consumes the RX head.
REQ-015 Port rd_data output pckg_sz: RX FIFO head, valid while rx_valid=1.
REQ-016 Port rx_valid output 1: RX FIFO non-empty.
REQ-017 Port rx_ovf output 1: sticky flag, an RX packet was dropped.
REQ-018 Port tx_err output 1: sticky flag, a TX write was rejected.

Function
REQ-019 Both FIFOs shall be first-word-fall-through; the head is visible combinationally from storage, and an entry written at edge N is visible after edge N.
REQ-020 A TX write shall occur when wr_en=1 and tx_full=0; the pckg_sz-bit word is stored unchanged.
REQ-021 wr_en=1 while tx_full=1, or with destination field equal to id (self-send), shall be rejected without a write and shall set tx_err.
REQ-022 pop=1 with pndng=1 shall advance the TX read pointer; pop=1 with pndng=0 shall be ignored.
REQ-023 Simultaneous pop and wr_en on a full TX FIFO shall accept both; occupancy is unchanged and tx_err is not set.
REQ-024 push=1 shall write D_push into the RX FIFO when it is not full.
REQ-025 push=1 on a full RX FIFO, unless rd_en=1 in the same cycle, shall drop the packet and set rx_ovf; the bus has no backpressure.
REQ-026 The RX FIFO shall accept only packets whose destination field equals id or 8'hFF (broadcast); all other packets are silently discarded without setting rx_ovf.
REQ-027 rd_en=1 with rx_valid=0 shall be ignored.
REQ-028 Pointers shall be log2(depth)+1 bits, wrapping modulo 2*depth; full means the MSBs differ and the LSBs are equal; empty means the pointers are equal.
REQ-029 rx_ovf and tx_err shall remain set until reset.

Reset
REQ-030 reset=0 shall asynchronously clear all pointers: pndng=0, tx_full=0, rx_valid=0, rx_ovf=0, tx_err=0.
REQ-031 D_pop and rd_data are don't-care while pndng/rx_valid=0; storage is not cleared.
REQ-032 Reset asserted mid-transfer shall discard all queued packets; the first push or wr_en after deassertion is stored at entry 0.

Configuration
REQ-033 With BUS_EP_DROP_CNT_EN defined: add output drop_cnt, 8 bits; it increments on each RX overflow drop, saturates at 255, and resets to 0.
REQ-034 Without BUS_EP_DROP_CNT_EN: no drop_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-035 Write 3 packets 0x0300..0x0302 via wr_en -> pndng=1, D_pop=0x0300; 3 pops return them in order, then pndng=0.
REQ-036 depth=8: write 9 TX packets -> tx_full=1 after the 8th; the 9th is rejected; tx_err=1.
REQ-037 id=2: push 0x02AB, 0xFF11, 0x0533 -> RX holds 0x02AB, 0xFF11 only; rx_valid=1.
REQ-038 Fill RX with 8 packets, push a 9th -> dropped, rx_ovf=1; drop_cnt=1 with BUS_EP_DROP_CNT_EN; push plus rd_en when full -> accepted.
REQ-039 Full TX with pop and wr_en in the same cycle -> occupancy stays 8; new word exits 8th; tx_err=0.
REQ-040 Assert reset with 5 entries queued -> pndng=0 and rx_valid=0 immediately, without a clk edge; next write is read back correctly.
